fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Control-side counterpart of the execute-stage forwarding datapath.
- Tracks destination registers of in-flight instructions in a 4-entry stage scoreboard (EX, MEM, WB, WB2).
- Generates the registered 2-bit forwarding selects consumed in EX, plus the load-use stall/bubble control for the ID/EX boundary.
- Sits beside the ID/EX pipeline register and is driven by decode.

Parameters:
- REG_AW, 5, register-address width; register indices 0..2^REG_AW-1.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  a real instruction is in ID
- id_rs1  input  REG_AW  source register A of ID instruction
- id_rs2  input  REG_AW  source register B of ID instruction
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_rd  input  REG_AW  destination of ID instruction
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load
- flush  input  1  kill ID instruction (branch redirect)
- freeze  input  1  global pipeline hold
- sel_fw_a  output  2  operand-A select for EX: 0 regfile, 1 MEM-stage value, 2 WB-stage value, 3 WB2 (post-writeback) value
- sel_fw_b  output  2  operand-B select, same encoding
- stall  output  1  load-use hazard; hold PC and IF/ID
- ex_bubble  output  1  registered; EX holds an inserted bubble

Behaviour:
- Scoreboard entry = {valid, rd, reg_write, mem_read}; entries E_EX, E_MEM, E_WB, E_WB2.
- Reset (async, rst_n=0): all entries invalid; sel_fw_a=sel_fw_b=0; ex_bubble=1. stall is combinational and therefore 0 with empty scoreboard.
- Producer p "matches" source s when p.valid & p.reg_write & p.rd==s & use_s.
- Hazard (combinational): stall = id_valid & ~flush & E_EX.valid & E_EX.mem_read & E_EX.reg_write & (match rs1 | match rs2 against E_EX.rd).
- Select computation for ID instruction (combinational, registered at edge), nearest producer wins:
  - match E_EX -> 1 (value will be in MEM next cycle)
  - else match E_MEM -> 2
  - else match E_WB -> 3
  - else 0
- Clock edge, priority order:
  - freeze=1: all state and outputs hold; stall still reflects current hazard.
  - else flush=1 or stall=1 or id_valid=0: shift E_WB2<=E_WB, E_WB<=E_MEM, E_MEM<=E_EX, E_EX<=invalid; sel_fw_a/b<=0; ex_bubble<=1.
  - else: shift as above with E_EX<={1,id_rd,id_reg_write,id_mem_read}; sel_fw_a/b<=computed selects; ex_bubble<=0.
- Latency: selects valid one cycle after ID presentation, aligned with the instruction in EX. A load-use costs exactly 1 stall cycle. Afterwards the load is in E_MEM when the consumer is in ID, so the consumer gets select 2.
- Boundaries:
  - rs1==rs2 with both used: both selects identical.
  - Producer with reg_write=0 never matches.
  - flush during stall: flush wins and stall deasserts.
  - rst_n mid-operation: immediate clear, no partial shift.

Optional Feature:
- FWD_ZERO_REG_EN defined: register 0 is hardwired zero; rd==0 never matches (no forward, no stall), and its selects are always 0.
- Undefined: register 0 is an ordinary register and forwards like any other.

Test Plan:
- Back-to-back ALU: ADD rd=3, then SUB rs1=3 -> next cycle sel_fw_a=1, sel_fw_b=0, stall=0.
- Distance 2 and 3: rd=7 producer, then nops, then consumer rs2=7 at gap 1/2 -> sel_fw_b=2 then 3 respectively; gap 3 -> 0.
- Load-use: LW rd=4, then ADD rs1=4 -> stall=1 one cycle, ex_bubble=1; following cycle stall=0, consumer enters EX with sel_fw_a=2.
- Priority: ADD rd=5 twice consecutively, then rs1=rs2=5 -> both selects 1 (nearest).
- Freeze for 3 cycles mid-sequence -> selects/ex_bubble unchanged; flush with pending load-use -> stall=0, bubble inserted.
- rd=0 producer, consumer rs1=0: with FWD_ZERO_REG_EN -> sel_fw_a=0; without -> sel_fw_a=1. Async rst_n pulse mid-stream -> outputs 0/0/ex_bubble=1 immediately.

Source files
------------

// File: rtl/fwd_hazard_if.sv
// Decode-side bundle for the forwarding/hazard control unit.
// Decode owns the master side; the hazard unit is the slave.
interface fwd_hazard_if #(
   parameter int REG_AW = 5
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              flush;
   logic              freeze;
   logic [1:0]        sel_fw_a;
   logic [1:0]        sel_fw_b;
   logic              stall;
   logic              ex_bubble;

   modport master (
      output id_valid, id_rs1, id_rs2,
      output id_use_rs1, id_use_rs2,
      output id_rd, id_reg_write, id_mem_read,
      output flush, freeze,
      input  sel_fw_a, sel_fw_b, stall, ex_bubble
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2,
      input  id_use_rs1, id_use_rs2,
      input  id_rd, id_reg_write, id_mem_read,
      input  flush, freeze,
      output sel_fw_a, sel_fw_b, stall, ex_bubble
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select / load-use stall control beside the ID/EX register.
// Optional macro FWD_ZERO_REG_EN: register 0 is hardwired zero.
module fwd_hazard_unit #(
   parameter int REG_AW = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   fwd_hazard_if.slave bus
);

   typedef logic [REG_AW-1:0] reg_t;

   typedef struct packed {
      logic valid;
      reg_t rd;
      logic reg_write;
      logic mem_read;
   } sb_entry_t;

   sb_entry_t e_ex;
   sb_entry_t e_mem;
   sb_entry_t e_wb;
   sb_entry_t e_wb2;

   logic a_ex, a_mem, a_wb;
   logic b_ex, b_mem, b_wb;
   logic [1:0] sel_a_nxt;
   logic [1:0] sel_b_nxt;
   logic stall_c;
   logic advance;
   sb_entry_t id_entry;

   function automatic logic hit(
      input sb_entry_t p,
      input reg_t      s,
      input logic      use_s
   );
      logic h;
      h = p.valid & p.reg_write & (p.rd == s) & use_s;
`ifdef FWD_ZERO_REG_EN
      if (s == '0) h = 1'b0;
`endif
      return h;
   endfunction

   // Nearest in-flight producer wins.
   function automatic logic [1:0] pick(
      input logic h_ex,
      input logic h_mem,
      input logic h_wb
   );
      logic [1:0] s;
      if (h_ex)       s = 2'd1;
      else if (h_mem) s = 2'd2;
      else if (h_wb)  s = 2'd3;
      else            s = 2'd0;
      return s;
   endfunction

   always_comb begin
      a_ex  = hit(e_ex,  bus.id_rs1, bus.id_use_rs1);
      a_mem = hit(e_mem, bus.id_rs1, bus.id_use_rs1);
      a_wb  = hit(e_wb,  bus.id_rs1, bus.id_use_rs1);
      b_ex  = hit(e_ex,  bus.id_rs2, bus.id_use_rs2);
      b_mem = hit(e_mem, bus.id_rs2, bus.id_use_rs2);
      b_wb  = hit(e_wb,  bus.id_rs2, bus.id_use_rs2);
      sel_a_nxt = pick(a_ex, a_mem, a_wb);
      sel_b_nxt = pick(b_ex, b_mem, b_wb);
   end

   // A load in EX cannot feed the ID consumer until it reaches MEM.
   always_comb begin
      stall_c = bus.id_valid & ~bus.flush
              & e_ex.valid & e_ex.mem_read
              & (a_ex | b_ex);
      advance = bus.id_valid & ~bus.flush & ~stall_c;
      id_entry.valid     = 1'b1;
      id_entry.rd        = bus.id_rd;
      id_entry.reg_write = bus.id_reg_write;
      id_entry.mem_read  = bus.id_mem_read;
   end

   assign bus.stall = stall_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_ex          <= '0;
         e_mem         <= '0;
         e_wb          <= '0;
         e_wb2         <= '0;
         bus.sel_fw_a  <= 2'd0;
         bus.sel_fw_b  <= 2'd0;
         bus.ex_bubble <= 1'b1;
      end else if (!bus.freeze) begin
         e_wb2 <= e_wb;
         e_wb  <= e_mem;
         e_mem <= e_ex;
         if (advance) begin
            e_ex          <= id_entry;
            bus.sel_fw_a  <= sel_a_nxt;
            bus.sel_fw_b  <= sel_b_nxt;
            bus.ex_bubble <= 1'b0;
         end else begin
            e_ex          <= '0;
            bus.sel_fw_a  <= 2'd0;
            bus.sel_fw_b  <= 2'd0;
            bus.ex_bubble <= 1'b1;
         end
      end
   end

   // WB2 is tracked for pipeline bookkeeping only; no select reads it.
   logic wb2_unused;
   assign wb2_unused = ^e_wb2;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit.
// Expected selects/stall values are hand-derived per step.
module tb_fwd_hazard_unit;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

`ifdef FWD_ZERO_REG_EN
   localparam logic [3:0] ZEXP = 4'd0;
`else
   localparam logic [3:0] ZEXP = 4'd1;
`endif

   fwd_hazard_if #(.REG_AW(5)) bus ();

   fwd_hazard_unit #(.REG_AW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic op(input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic rw,
                     input logic mr);
      bus.id_valid     = 1'b1;
      bus.id_rs1       = rs1;
      bus.id_use_rs1   = u1;
      bus.id_rs2       = rs2;
      bus.id_use_rs2   = u2;
      bus.id_rd        = rd;
      bus.id_reg_write = rw;
      bus.id_mem_read  = mr;
   endtask

   task automatic nop();
      op(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      bus.id_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.flush  = 1'b0;
      bus.freeze = 1'b0;
      nop();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_sel_a", {2'b0, bus.sel_fw_a}, 4'd0);
      chk("rst_sel_b", {2'b0, bus.sel_fw_b}, 4'd0);
      chk("rst_bubble", {3'b0, bus.ex_bubble}, 4'd1);
      chk("rst_stall", {3'b0, bus.stall}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // back-to-back ALU
      op(5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
      tick();
      chk("b2b_bubble", {3'b0, bus.ex_bubble}, 4'd0);
      op(5'd3, 1, 5'd6, 1, 5'd8, 1, 0);
      #1 chk("b2b_stall", {3'b0, bus.stall}, 4'd0);
      tick();
      chk("b2b_sel_a", {2'b0, bus.sel_fw_a}, 4'd1);
      chk("b2b_sel_b", {2'b0, bus.sel_fw_b}, 4'd0);

      // distance 2: one nop gap
      op(5'd0, 0, 5'd0, 0, 5'd7, 1, 0);
      tick();
      nop();
      tick();
      chk("gap1_bubble", {3'b0, bus.ex_bubble}, 4'd1);
      op(5'd7, 0, 5'd7, 1, 5'd10, 1, 0);
      tick();
      chk("gap1_sel_b", {2'b0, bus.sel_fw_b}, 4'd2);
      chk("gap1_unused_a", {2'b0, bus.sel_fw_a}, 4'd0);

      // distance 3: two nop gap
      op(5'd0, 0, 5'd0, 0, 5'd12, 1, 0);
      tick();
      nop();
      tick();
      tick();
      op(5'd9, 1, 5'd12, 1, 5'd23, 1, 0);
      tick();
      chk("gap2_sel_b", {2'b0, bus.sel_fw_b}, 4'd3);
      chk("gap2_sel_a", {2'b0, bus.sel_fw_a}, 4'd0);

      // three nop gap: out of forwarding range
      op(5'd0, 0, 5'd0, 0, 5'd13, 1, 0);
      tick();
      nop();
      tick();
      tick();
      tick();
      op(5'd9, 1, 5'd13, 1, 5'd24, 1, 0);
      tick();
      chk("gap3_sel_b", {2'b0, bus.sel_fw_b}, 4'd0);

      // load-use
      op(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
      tick();
      op(5'd4, 1, 5'd14, 1, 5'd15, 1, 0);
      #1 chk("lu_stall", {3'b0, bus.stall}, 4'd1);
      tick();
      chk("lu_bubble", {3'b0, bus.ex_bubble}, 4'd1);
      chk("lu_bub_sel_a", {2'b0, bus.sel_fw_a}, 4'd0);
      chk("lu_stall_clr", {3'b0, bus.stall}, 4'd0);
      tick();
      chk("lu_sel_a", {2'b0, bus.sel_fw_a}, 4'd2);
      chk("lu_sel_b", {2'b0, bus.sel_fw_b}, 4'd0);
      chk("lu_issue", {3'b0, bus.ex_bubble}, 4'd0);

      // nearest producer priority
      op(5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
      tick();
      op(5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
      tick();
      op(5'd5, 1, 5'd5, 1, 5'd16, 1, 0);
      tick();
      chk("prio_sel_a", {2'b0, bus.sel_fw_a}, 4'd1);
      chk("prio_sel_b", {2'b0, bus.sel_fw_b}, 4'd1);

      // non-writing producer
      op(5'd0, 0, 5'd0, 0, 5'd17, 0, 0);
      tick();
      op(5'd17, 1, 5'd17, 1, 5'd25, 1, 0);
      tick();
      chk("nowr_sel_a", {2'b0, bus.sel_fw_a}, 4'd0);
      chk("nowr_sel_b", {2'b0, bus.sel_fw_b}, 4'd0);

      // freeze holds outputs and scoreboard
      op(5'd0, 0, 5'd0, 0, 5'd18, 1, 0);
      tick();
      op(5'd18, 1, 5'd0, 0, 5'd19, 1, 0);
      tick();
      chk("frz_pre_a", {2'b0, bus.sel_fw_a}, 4'd1);
      op(5'd0, 0, 5'd19, 1, 5'd26, 1, 0);
      bus.freeze = 1'b1;
      tick();
      tick();
      tick();
      chk("frz_sel_a", {2'b0, bus.sel_fw_a}, 4'd1);
      chk("frz_sel_b", {2'b0, bus.sel_fw_b}, 4'd0);
      chk("frz_bubble", {3'b0, bus.ex_bubble}, 4'd0);
      bus.freeze = 1'b0;
      tick();
      chk("frz_rel_b", {2'b0, bus.sel_fw_b}, 4'd1);
      chk("frz_rel_a", {2'b0, bus.sel_fw_a}, 4'd0);

      // flush beats pending load-use
      op(5'd0, 0, 5'd0, 0, 5'd20, 1, 1);
      tick();
      op(5'd20, 1, 5'd0, 0, 5'd27, 1, 0);
      #1 chk("fl_stall_pre", {3'b0, bus.stall}, 4'd1);
      bus.flush = 1'b1;
      #1 chk("fl_stall", {3'b0, bus.stall}, 4'd0);
      tick();
      chk("fl_bubble", {3'b0, bus.ex_bubble}, 4'd1);
      chk("fl_sel_a", {2'b0, bus.sel_fw_a}, 4'd0);
      bus.flush = 1'b0;
      tick();
      chk("fl_after_a", {2'b0, bus.sel_fw_a}, 4'd2);

      // register 0 producer
      op(5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
      tick();
      op(5'd0, 1, 5'd0, 0, 5'd28, 1, 0);
      tick();
      chk("r0_sel_a", {2'b0, bus.sel_fw_a}, ZEXP);

      // async reset mid-stream
      op(5'd0, 0, 5'd0, 0, 5'd22, 1, 0);
      tick();
      op(5'd22, 1, 5'd22, 1, 5'd29, 1, 0);
      tick();
      chk("ar_pre_a", {2'b0, bus.sel_fw_a}, 4'd1);
      op(5'd22, 1, 5'd0, 0, 5'd30, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_sel_a", {2'b0, bus.sel_fw_a}, 4'd0);
      chk("ar_sel_b", {2'b0, bus.sel_fw_b}, 4'd0);
      chk("ar_bubble", {3'b0, bus.ex_bubble}, 4'd1);
      chk("ar_stall", {3'b0, bus.stall}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ar_post_a", {2'b0, bus.sel_fw_a}, 4'd0);
      chk("ar_post_bub", {3'b0, bus.ex_bubble}, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
